keypad_scanner: RTL and testbench

//  Upstream stage of the keypad FSM. Drives keypad rows active-low one at a time and synchronizes the raw

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_scanner_if.sv | 30 +++
 rtl/sync_bus.sv | 26 ++
 rtl/keypad_scanner.sv | 76 +++++++
 tb/tb_keypad_scanner.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan path.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef logic [3:0] onehot4_t;

    typedef struct packed {
        onehot4_t row;
        onehot4_t col;
    } rowcol_t;

    function automatic onehot4_t idx2oh(input logic [1:0] idx);
        idx2oh = 4'b0001 << idx;
    endfunction

    // Only meaningful for one-hot inputs; callers qualify with $onehot first.
    function automatic logic [1:0] oh2idx(input onehot4_t oh);
        unique case (oh)
            4'b0010: oh2idx = 2'd1;
            4'b0100: oh2idx = 2'd2;
            4'b1000: oh2idx = 2'd3;
            default: oh2idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Scanner boundary: keypad pads on one side, downstream keypad FSM on the other.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [COLS-1:0] colIn_n;
    logic [ROWS-1:0] rowDrive_n;
    logic            rowLocked;
    onehot4_t        rowLock;
    rowcol_t         rowCol;
    logic            scanTick;

    modport master (
        input  colIn_n,
        input  rowLocked,
        input  rowLock,
        output rowDrive_n,
        output rowCol,
        output scanTick
    );

    modport slave (
        output colIn_n,
        output rowLocked,
        output rowLock,
        input  rowDrive_n,
        input  rowCol,
        input  scanTick
    );

endinterface

// File: rtl/sync_bus.sv
// Multi-stage flop synchronizer for a bus of independent asynchronous bits.
module sync_bus #(
    parameter int               WIDTH   = 4,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// Keypad row scanner: rotates active-low row drive, samples synchronized columns once per dwell.
// Build option KEYPAD_MULTIKEY_REJECT_EN drops samples with more than one column active.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       row_idx_nxt;
    onehot4_t         col_raw;
    onehot4_t         col_sync;
    onehot4_t         col_sample;
    rowcol_t          row_col_q;
    logic             tick;

    sync_bus #(
        .WIDTH   (COLS),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ({COLS{1'b1}})
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.colIn_n),
        .q     (col_raw)
    );

    assign col_sync = ~col_raw;

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    assign col_sample = ((col_sync & (col_sync - 4'd1)) != 4'd0) ? 4'b0000 : col_sync;
`else
    assign col_sample = col_sync;
`endif

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     div_cnt <= '0;
        else if (tick)  div_cnt <= '0;
        else            div_cnt <= div_cnt + DIV_W'(1);
    end

    // A held lock overrides the tick; an invalid lock vector freezes the row.
    always_comb begin
        row_idx_nxt = row_idx;
        if (bus.rowLocked) begin
            if ($onehot(bus.rowLock)) row_idx_nxt = oh2idx(bus.rowLock);
        end else if (tick) begin
            row_idx_nxt = row_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) row_idx <= 2'd0;
        else        row_idx <= row_idx_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    row_col_q <= '0;
        else if (tick) row_col_q <= '{row: idx2oh(row_idx), col: col_sample};
    end

    assign bus.rowDrive_n = ~idx2oh(row_idx);
    assign bus.rowCol     = row_col_q;
    assign bus.scanTick   = tick;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, SYNC_STAGES=2.
module tb_keypad_scanner;

    localparam int SCAN_DIV    = 4;
    localparam int SYNC_STAGES = 2;
    localparam logic [3:0] OH [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    keypad_scanner_if bus();

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench on a negedge with reset just released (cycle k=0).
    task automatic apply_reset();
        @(negedge clk);
        reset         = 1'b0;
        bus.colIn_n   = 4'hF;
        bus.rowLocked = 1'b0;
        bus.rowLock   = 4'b0000;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset       = 1'b0;
        bus.colIn_n = 4'b0000;
        step();
        step();
        step();
        n_cmp++;
        if (bus.rowDrive_n !== 4'b1110) begin
            n_bad++; $display("FAIL reset_rowDrive got %h want e", bus.rowDrive_n);
        end
        n_cmp++;
        if (bus.rowCol !== 8'h00) begin
            n_bad++; $display("FAIL reset_rowCol got %h want 00", bus.rowCol);
        end
        n_cmp++;
        if (bus.scanTick !== 1'b0) begin
            n_bad++; $display("FAIL reset_scanTick got %b want 0", bus.scanTick);
        end
    endtask

    task automatic test_idle();
        logic [3:0] exp_drv;
        logic       exp_tick;
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_tick = ((k % 4) == 3);
            exp_drv  = ~OH[2'((k / 4) % 4)];
            n_cmp++;
            if (bus.scanTick !== exp_tick) begin
                n_bad++; $display("FAIL idle_tick k=%0d got %b want %b", k, bus.scanTick, exp_tick);
            end
            n_cmp++;
            if (bus.rowDrive_n !== exp_drv) begin
                n_bad++; $display("FAIL idle_rowDrive k=%0d got %h want %h", k, bus.rowDrive_n, exp_drv);
            end
            if ((k % 4) == 0) begin
                n_cmp++;
                if (bus.rowCol !== {OH[2'((k / 4 - 1) % 4)], 4'h0}) begin
                    n_bad++; $display("FAIL idle_rowCol k=%0d got %h want %h", k, bus.rowCol,
                                      {OH[2'((k / 4 - 1) % 4)], 4'h0});
                end
            end
        end
    endtask

    task automatic test_single_key();
        logic [7:0] exp_rc [4];
        exp_rc = '{8'h10, 8'h24, 8'h40, 8'h80};
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            bus.colIn_n = (bus.rowDrive_n == 4'b1101) ? 4'b1011 : 4'hF;
            step();
            if ((k % 4) == 0) begin
                n_cmp++;
                if (bus.rowCol !== exp_rc[2'(k / 4 - 1)]) begin
                    n_bad++; $display("FAIL key_rowCol k=%0d got %h want %h", k, bus.rowCol, exp_rc[2'(k / 4 - 1)]);
                end
            end
        end
        bus.colIn_n = 4'hF;
    endtask

    task automatic test_lock();
        int ticks = 0;
        apply_reset();
        for (int k = 1; k <= 8; k++) step();
        bus.colIn_n = 4'b1110;
        step();
        bus.rowLocked = 1'b1;
        bus.rowLock   = 4'b0100;
        for (int k = 10; k <= 21; k++) begin
            step();
            if (bus.scanTick === 1'b1) ticks++;
            n_cmp++;
            if (bus.rowDrive_n !== 4'b1011) begin
                n_bad++; $display("FAIL lock_rowDrive k=%0d got %h want b", k, bus.rowDrive_n);
            end
            if ((k % 4) == 0) begin
                n_cmp++;
                if (bus.rowCol !== 8'h41) begin
                    n_bad++; $display("FAIL lock_rowCol k=%0d got %h want 41", k, bus.rowCol);
                end
            end
        end
        n_cmp++;
        if (ticks !== 3) begin
            n_bad++; $display("FAIL lock_ticks got %0d want 3", ticks);
        end
        bus.rowLocked = 1'b0;
        bus.colIn_n   = 4'hF;
        step();
        step();
        n_cmp++;
        if ({bus.scanTick, bus.rowDrive_n} !== 5'b1_1011) begin
            n_bad++; $display("FAIL unlock_pre got tick=%b drv=%h want tick=1 drv=b", bus.scanTick, bus.rowDrive_n);
        end
        step();
        n_cmp++;
        if (bus.rowDrive_n !== 4'b0111) begin
            n_bad++; $display("FAIL unlock_rowDrive got %h want 7", bus.rowDrive_n);
        end
        n_cmp++;
        if (bus.rowCol !== 8'h40) begin
            n_bad++; $display("FAIL unlock_rowCol got %h want 40", bus.rowCol);
        end
        // Relock elsewhere: jump at once, then hold on multi-hot and zero lock vectors.
        bus.rowLocked = 1'b1;
        bus.rowLock   = 4'b0001;
        step();
        n_cmp++;
        if (bus.rowDrive_n !== 4'b1110) begin
            n_bad++; $display("FAIL relock_jump got %h want e", bus.rowDrive_n);
        end
        bus.rowLock = 4'b0110;
        for (int k = 26; k <= 28; k++) begin
            step();
            n_cmp++;
            if (bus.rowDrive_n !== 4'b1110) begin
                n_bad++; $display("FAIL multihot_hold k=%0d got %h want e", k, bus.rowDrive_n);
            end
        end
        n_cmp++;
        if (bus.rowCol !== 8'h10) begin
            n_bad++; $display("FAIL multihot_rowCol got %h want 10", bus.rowCol);
        end
        bus.rowLock = 4'b0000;
        step();
        n_cmp++;
        if (bus.rowDrive_n !== 4'b1110) begin
            n_bad++; $display("FAIL zerolock_hold got %h want e", bus.rowDrive_n);
        end
        bus.rowLocked = 1'b0;
        step();
        step();
        n_cmp++;
        if (bus.rowDrive_n !== 4'b1110) begin
            n_bad++; $display("FAIL unlock2_pre got %h want e", bus.rowDrive_n);
        end
        step();
        n_cmp++;
        if (bus.rowDrive_n !== 4'b1101) begin
            n_bad++; $display("FAIL unlock2_rowDrive got %h want d", bus.rowDrive_n);
        end
    endtask

    task automatic test_multikey();
        logic [7:0] exp0, exp1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        exp0 = 8'h10;
        exp1 = 8'h20;
`else
        exp0 = 8'h13;
        exp1 = 8'h2A;
`endif
        apply_reset();
        bus.colIn_n = 4'b1100;
        for (int k = 1; k <= 4; k++) step();
        n_cmp++;
        if (bus.rowCol !== exp0) begin
            n_bad++; $display("FAIL multikey_row0 got %h want %h", bus.rowCol, exp0);
        end
        bus.colIn_n = 4'b0101;
        for (int k = 5; k <= 8; k++) step();
        n_cmp++;
        if (bus.rowCol !== exp1) begin
            n_bad++; $display("FAIL multikey_row1 got %h want %h", bus.rowCol, exp1);
        end
        bus.colIn_n = 4'hF;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 1; k <= 12; k++) step();
        bus.colIn_n = 4'b0111;
        step();
        step();
        n_cmp++;
        if ({bus.rowDrive_n, bus.rowCol} !== 12'h7_40) begin
            n_bad++; $display("FAIL midrst_pre got drv=%h rc=%h want drv=7 rc=40", bus.rowDrive_n, bus.rowCol);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.rowDrive_n !== 4'b1110) begin
            n_bad++; $display("FAIL midrst_rowDrive got %h want e", bus.rowDrive_n);
        end
        n_cmp++;
        if (bus.rowCol !== 8'h00) begin
            n_bad++; $display("FAIL midrst_rowCol got %h want 00", bus.rowCol);
        end
        n_cmp++;
        if (bus.scanTick !== 1'b0) begin
            n_bad++; $display("FAIL midrst_scanTick got %b want 0", bus.scanTick);
        end
        step();
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (bus.scanTick !== (k == 3)) begin
                n_bad++; $display("FAIL midrst_tick k=%0d got %b want %b", k, bus.scanTick, (k == 3));
            end
        end
        n_cmp++;
        if (bus.rowCol !== 8'h18) begin
            n_bad++; $display("FAIL midrst_sample got %h want 18", bus.rowCol);
        end
        bus.colIn_n = 4'hF;
    endtask

    task automatic test_glitch();
        apply_reset();
        step();
        #1 bus.colIn_n = 4'b1110;
        #2 bus.colIn_n = 4'hF;
        for (int k = 2; k <= 4; k++) step();
        n_cmp++;
        if (bus.rowCol !== 8'h10) begin
            n_bad++; $display("FAIL glitch_row0 got %h want 10", bus.rowCol);
        end
        step();
        step();
        #1 bus.colIn_n = 4'b1101;
        #2 bus.colIn_n = 4'hF;
        step();
        step();
        n_cmp++;
        if (bus.rowCol !== 8'h20) begin
            n_bad++; $display("FAIL glitch_row1 got %h want 20", bus.rowCol);
        end
    endtask

    initial begin
        bus.colIn_n   = 4'hF;
        bus.rowLocked = 1'b0;
        bus.rowLock   = 4'b0000;
        test_reset();
        test_idle();
        test_single_key();
        test_lock();
        test_multikey();
        test_reset_mid();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
